// File: rtl/dp_executor.sv
// Executes one datapath instruction (RAM read/write or VGA pixel plot) per start_dp rising edge.
// Completes in 1 edge (MEMWRITE/DRAW/NOP) or 2 edges (MEMREAD); start_dp outside IDLE is dropped.
module dp_executor #(
  parameter int OPCODE_WIDTH      = 2,
  parameter int MEM_ADDR_WIDTH    = 8,
  parameter int RESULT_WIDTH      = 8,
  parameter int X_COORD_WIDTH     = 8,
  parameter int Y_COORD_WIDTH     = 7,
  parameter int COLOUR_WIDTH      = 3,
  parameter int INSTRUCTION_WIDTH = 21
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
  output logic                         finished_dp,
  output logic [RESULT_WIDTH-1:0]      result_dp,
  output logic                         bad_op,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
  output logic [RESULT_WIDTH-1:0]      mem_wdata,
  output logic                         mem_we,
  input  logic [RESULT_WIDTH-1:0]      mem_rdata,
  output logic [X_COORD_WIDTH-1:0]     vga_x,
  output logic [Y_COORD_WIDTH-1:0]     vga_y,
  output logic [COLOUR_WIDTH-1:0]      vga_colour,
  output logic                         vga_plot
);

  localparam int ADDR_LO  = OPCODE_WIDTH;
  localparam int DATA_LO  = OPCODE_WIDTH + MEM_ADDR_WIDTH;
  localparam int X_LO     = OPCODE_WIDTH;
  localparam int Y_LO     = X_LO + X_COORD_WIDTH;
  localparam int C_LO     = Y_LO + Y_COORD_WIDTH;
  localparam int PLOT_BIT = C_LO + COLOUR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_MEMREAD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MEMWRITE = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_DRAW     = OPCODE_WIDTH'(3);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  logic [1:0]                state_q, state_d;
  logic                      start_q, start_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;
  logic                      finished_q, finished_d;
  logic [RESULT_WIDTH-1:0]   result_q, result_d;
  logic                      bad_op_q, bad_op_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [RESULT_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                      mem_we_q, mem_we_d;
  logic [X_COORD_WIDTH-1:0]  vga_x_q, vga_x_d;
  logic [Y_COORD_WIDTH-1:0]  vga_y_q, vga_y_d;
  logic [COLOUR_WIDTH-1:0]   vga_colour_q, vga_colour_d;
  logic                      vga_plot_q, vga_plot_d;
  logic [OPCODE_WIDTH-1:0]   op_in;

  assign op_in = instruction_dp[OPCODE_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    start_d      = start_dp;
    op_d         = op_q;
    finished_d   = finished_q;
    result_d     = result_q;
    bad_op_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = vga_plot_q;
    case (state_q)
      S_IDLE: begin
        // Rising-edge detect: a start held high across completion must not re-fire.
        if (start_dp && !start_q) begin
          op_d         = op_in;
          finished_d   = 1'b0;
          mem_addr_d   = instruction_dp[ADDR_LO +: MEM_ADDR_WIDTH];
          mem_wdata_d  = instruction_dp[DATA_LO +: RESULT_WIDTH];
          vga_x_d      = instruction_dp[X_LO +: X_COORD_WIDTH];
          vga_y_d      = instruction_dp[Y_LO +: Y_COORD_WIDTH];
          vga_colour_d = instruction_dp[C_LO +: COLOUR_WIDTH];
          mem_we_d     = (op_in == OP_MEMWRITE);
          vga_plot_d   = (op_in == OP_DRAW) && instruction_dp[PLOT_BIT];
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        mem_we_d   = 1'b0;
        vga_plot_d = 1'b0;
        finished_d = 1'b1;
        state_d    = S_IDLE;
        case (op_q)
          OP_MEMREAD: begin
            finished_d = 1'b0;
            state_d    = S_MEM_WAIT;
          end
          OP_MEMWRITE: result_d = mem_wdata_q;
          OP_DRAW:     result_d = '0;
          default: begin
            result_d = '0;
            bad_op_d = 1'b1;
          end
        endcase
      end
      S_MEM_WAIT: begin
        result_d   = mem_rdata;
        finished_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      op_q         <= '0;
      finished_q   <= 1'b1;
      result_q     <= '0;
      bad_op_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      op_q         <= op_d;
      finished_q   <= finished_d;
      result_q     <= result_d;
      bad_op_q     <= bad_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign finished_dp = finished_q;
  assign result_dp   = result_q;
  assign bad_op      = bad_op_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;

endmodule

// File: tb/tb_dp_executor.sv
// Directed bench for dp_executor with a 1-cycle-latency RAM model and per-cycle activity monitors.
module tb_dp_executor;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_dp = 1'b0;
  logic [20:0] instruction_dp = '0;
  logic        finished_dp;
  logic [7:0]  result_dp;
  logic        bad_op;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int errors = 0;
  int checks = 0;

  int we_cyc, plot_cyc, fin_low, bad_cyc;
  logic [7:0] we_addr, we_data, plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_c;
  logic [7:0] ram [256];

  dp_executor dut (
    .clock(clock), .reset(reset), .start_dp(start_dp), .instruction_dp(instruction_dp),
    .finished_dp(finished_dp), .result_dp(result_dp), .bad_op(bad_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clock) begin
    if (mem_we) begin
      we_cyc++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (vga_plot) begin
      plot_cyc++;
      plot_x = vga_x;
      plot_y = vga_y;
      plot_c = vga_colour;
    end
    if (!finished_dp) fin_low++;
    if (bad_op) bad_cyc++;
  end

  task automatic clear_mon();
    @(posedge clock);
    #2;
    we_cyc = 0; plot_cyc = 0; fin_low = 0; bad_cyc = 0;
  endtask

  task automatic run_instr(input logic [20:0] ins, input int hold);
    clear_mon();
    @(negedge clock);
    start_dp = 1'b1;
    instruction_dp = ins;
    repeat (hold) @(negedge clock);
    start_dp = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (finished_dp !== 1'b1) begin errors++; $display("FAIL reset_finished got=%b exp=1", finished_dp); end
    checks++; if (result_dp !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result_dp); end
    checks++; if ({mem_we, vga_plot, bad_op} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {mem_we, vga_plot, bad_op}); end
    checks++; if ({mem_addr, mem_wdata, vga_x} !== 24'h0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {mem_addr, mem_wdata, vga_x}); end
    // Async reset while a plot is in flight
    @(negedge clock);
    start_dp = 1'b1;
    instruction_dp = {1'b1, 3'b010, 7'd5, 8'd6, 2'd3};
    @(posedge clock);
    #3;
    checks++; if (vga_plot !== 1'b1) begin errors++; $display("FAIL rst_plot_pre got=%b exp=1", vga_plot); end
    reset = 1'b1;
    start_dp = 1'b0;
    #1;
    checks++; if ({vga_plot, finished_dp} !== 2'b01) begin errors++; $display("FAIL rst_plot_async got=%b exp=01", {vga_plot, finished_dp}); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    run_instr({3'b0, 8'hA5, 8'h12, 2'd2}, 2);
    checks++; if (we_cyc !== 1) begin errors++; $display("FAIL wr_we_cycles got=%0d exp=1", we_cyc); end
    checks++; if ({we_addr, we_data} !== 16'h12A5) begin errors++; $display("FAIL wr_addr_data got=%h exp=12a5", {we_addr, we_data}); end
    checks++; if (fin_low !== 1) begin errors++; $display("FAIL wr_fin_low got=%0d exp=1", fin_low); end
    checks++; if (result_dp !== 8'hA5) begin errors++; $display("FAIL wr_result got=%h exp=a5", result_dp); end
    // Drive result back to a different value so the read's result is meaningful
    run_instr(21'd0, 2);
    run_instr({11'b0, 8'h12, 2'd1}, 2);
    checks++; if (fin_low !== 2) begin errors++; $display("FAIL rd_fin_low got=%0d exp=2", fin_low); end
    checks++; if (we_cyc !== 0) begin errors++; $display("FAIL rd_we got=%0d exp=0", we_cyc); end
    checks++; if ({finished_dp, result_dp} !== 9'h1A5) begin errors++; $display("FAIL rd_result got=%h exp=1a5", {finished_dp, result_dp}); end
  endtask

  task automatic test_draw();
    run_instr({1'b1, 3'b100, 7'd59, 8'd159, 2'd3}, 2);
    checks++; if (plot_cyc !== 1) begin errors++; $display("FAIL draw_plot_cycles got=%0d exp=1", plot_cyc); end
    checks++; if ({plot_x, plot_y, plot_c} !== {8'd159, 7'd59, 3'b100}) begin errors++; $display("FAIL draw_coords got=%0d,%0d,%b exp=159,59,100", plot_x, plot_y, plot_c); end
    checks++; if ({finished_dp, result_dp} !== 9'h100) begin errors++; $display("FAIL draw_result got=%h exp=100", {finished_dp, result_dp}); end
    checks++; if (fin_low !== 1) begin errors++; $display("FAIL draw_fin_low got=%0d exp=1", fin_low); end
    run_instr({1'b0, 3'b100, 7'd59, 8'd159, 2'd3}, 2);
    checks++; if (plot_cyc !== 0) begin errors++; $display("FAIL draw0_plot got=%0d exp=0", plot_cyc); end
    checks++; if ({finished_dp, fin_low} !== {1'b1, 32'd1}) begin errors++; $display("FAIL draw0_finish got=%b/%0d exp=1/1", finished_dp, fin_low); end
  endtask

  task automatic test_held_start();
    run_instr({3'b0, 8'h77, 8'h30, 2'd2}, 10);
    checks++; if (we_cyc !== 1) begin errors++; $display("FAIL held_we_cycles got=%0d exp=1", we_cyc); end
    checks++; if (fin_low !== 1) begin errors++; $display("FAIL held_fin_low got=%0d exp=1", fin_low); end
    checks++; if (result_dp !== 8'h77) begin errors++; $display("FAIL held_result got=%h exp=77", result_dp); end
  endtask

  task automatic test_nop();
    run_instr(21'd0, 2);
    checks++; if (fin_low !== 1) begin errors++; $display("FAIL nop_fin_low got=%0d exp=1", fin_low); end
    checks++; if (bad_cyc !== 1) begin errors++; $display("FAIL nop_bad_op got=%0d exp=1", bad_cyc); end
    checks++; if (result_dp !== 8'h00) begin errors++; $display("FAIL nop_result got=%h exp=00", result_dp); end
    checks++; if (we_cyc + plot_cyc !== 0) begin errors++; $display("FAIL nop_strobes got=%0d exp=0", we_cyc + plot_cyc); end
  endtask

  task automatic test_reset_mid_write();
    clear_mon();
    @(negedge clock);
    start_dp = 1'b1;
    instruction_dp = {3'b0, 8'h3C, 8'h40, 2'd2};
    @(posedge clock);
    #3;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstwr_we_pre got=%b exp=1", mem_we); end
    reset = 1'b1;
    start_dp = 1'b0;
    #1;
    checks++; if ({mem_we, finished_dp} !== 2'b01) begin errors++; $display("FAIL rstwr_async got=%b exp=01", {mem_we, finished_dp}); end
    @(negedge clock);
    reset = 1'b0;
    run_instr({11'b0, 8'h40, 2'd1}, 2);
    checks++; if (fin_low !== 2) begin errors++; $display("FAIL rstwr_rd_fin_low got=%0d exp=2", fin_low); end
    checks++; if ({finished_dp, result_dp} !== 9'h11A) begin errors++; $display("FAIL rstwr_rd_result got=%h exp=11a", {finished_dp, result_dp}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_write_read();
    test_draw();
    test_held_start();
    test_nop();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
